native2axil_adapter: RTL and testbench
======================================

// Module: native2axil_adapter
// PURPOSE
//  Bridges a native-interface master (CPU/DMA) onto an AXI4-Lite master port so native initiators can reach AXI-Lite peripherals and memories.
//  Reverse of the AXI-Lite-slave-to-native path. Handles one transaction at a time. Registered FSM, no combinational path from native inputs to AXI outputs.
// PARAMETERS
//  DATA_WIDTH  32             data bus width in bits
//  ADDR_WIDTH  32             address bus width in bits
//  STRB_WIDTH  DATA_WIDTH/8   byte-strobe width
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst_n            in   1           asynchronous active-low reset
//  native_valid     in   1           request valid; held high until native_ready
//  native_ready     out  1           one-cycle completion pulse
//  native_addr      in   ADDR_WIDTH  byte address
//  native_wdata     in   DATA_WIDTH  write data
//  native_wstrb     in   STRB_WIDTH  byte enables; nonzero=write, zero=read
//  native_rdata     out  DATA_WIDTH  read data, valid while native_ready=1
//  native_error     out  1           with native_ready: AXI resp was SLVERR/DECERR
//  m_axil_awaddr    out  ADDR_WIDTH  write address
//  m_axil_awprot    out  3           tied 3'b000
//  m_axil_awvalid   out  1           write address valid
//  m_axil_awready   in   1           write address ready
//  m_axil_wdata     out  DATA_WIDTH  write data
//  m_axil_wstrb     out  STRB_WIDTH  write strobes
//  m_axil_wvalid    out  1           write data valid
//  m_axil_wready    in   1           write data ready
//  m_axil_bresp     in   2           write response
//  m_axil_bvalid    in   1           write response valid
//  m_axil_bready    out  1           write response ready
//  m_axil_araddr    out  ADDR_WIDTH  read address
//  m_axil_arprot    out  3           tied 3'b000
//  m_axil_arvalid   out  1           read address valid
//  m_axil_arready   in   1           read address ready
//  m_axil_rdata     in   DATA_WIDTH  read data
//  m_axil_rresp     in   2           read response
//  m_axil_rvalid    in   1           read data valid
//  m_axil_rready    out  1           read data ready
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all valid/ready outputs 0; native_rdata=0, native_error=0, addr/data/strb regs=0.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
//  IDLE and native_valid=1: latch addr/wdata/wstrb. wstrb!=0 -> WR_REQ with awvalid=wvalid=1 next cycle. wstrb==0 -> RD_REQ with arvalid=1 next cycle.
//  WR_REQ: AW and W complete independently. awvalid drops the cycle after awvalid&awready. wvalid drops the cycle after wvalid&wready. Either order or same cycle is legal.
//  WR_REQ exit: both handshakes done -> WR_RESP. Valids never drop before their handshake, and their payloads stay stable.
//  WR_RESP: bready=1. On bvalid: capture error=|bresp -> DONE.
//  RD_REQ: arvalid=1 until arready -> RD_RESP.
//  RD_RESP: rready=1. On rvalid: capture rdata and error=|rresp -> DONE.
//  DONE: native_ready=1 for exactly one cycle, native_rdata/native_error valid -> IDLE. native_valid is ignored in DONE. A new request is sampled only in IDLE.
//  Minimum latency, zero-wait slave: valid@T0 -> aw/w/ar valid@T1 -> bready/rready handshake@T2 -> native_ready@T3.
//  native_rdata holds its last read value until the next read completes. It is not cleared on writes.
//  No timeout. The bridge waits indefinitely on a stalled slave.
//  Reset mid-transaction aborts immediately to IDLE. The AXI slave must be reset in the same domain.
// TESTING
//  Write 0xA5A5_0001 to 0x10, wstrb=4'hF, zero-wait slave -> aw/w valid together T1; native_ready T3; native_error=0.
//  Read 0x20, slave returns 0xDEAD_BEEF with 2-cycle arready and 3-cycle rvalid delay -> native_ready one cycle with rdata=0xDEAD_BEEF.
//  Write with wready 4 cycles after awready -> awvalid drops after AW handshake; wvalid held stable; exactly one B accepted.
//  bresp=2'b10 on write, then rresp=2'b11 on read -> native_error=1 with each native_ready pulse.
//  Back-to-back requests with native_valid held high across DONE -> second transaction launches from IDLE, no duplicate AXI transfer.
//  rst_n asserted in WR_RESP -> all AXI valids/readys 0 asynchronously; after release, a read completes normally.

Source files
------------

// File: rtl/native2axil_adapter_if.sv
// Bus bundles for the native-to-AXI4-Lite bridge: the native request port and the AXI4-Lite master port.
// Each carries master/slave modports seen from the initiator and the target of that bus.

interface native_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  native_valid;
  logic                  native_ready;
  logic [ADDR_WIDTH-1:0] native_addr;
  logic [DATA_WIDTH-1:0] native_wdata;
  logic [STRB_WIDTH-1:0] native_wstrb;
  logic [DATA_WIDTH-1:0] native_rdata;
  logic                  native_error;

  modport master (
    output native_valid, native_addr, native_wdata, native_wstrb,
    input  native_ready, native_rdata, native_error
  );

  modport slave (
    input  native_valid, native_addr, native_wdata, native_wstrb,
    output native_ready, native_rdata, native_error
  );
endinterface

interface axil_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] m_axil_awaddr;
  logic [2:0]            m_axil_awprot;
  logic                  m_axil_awvalid;
  logic                  m_axil_awready;
  logic [DATA_WIDTH-1:0] m_axil_wdata;
  logic [STRB_WIDTH-1:0] m_axil_wstrb;
  logic                  m_axil_wvalid;
  logic                  m_axil_wready;
  logic [1:0]            m_axil_bresp;
  logic                  m_axil_bvalid;
  logic                  m_axil_bready;
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic [2:0]            m_axil_arprot;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [DATA_WIDTH-1:0] m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;

  modport master (
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );

  modport slave (
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/native2axil_adapter.sv
// Single-outstanding bridge from a native request/ready master onto an AXI4-Lite master port.
// Every output comes straight from a flop, so native inputs never reach the AXI side combinationally.

module native2axil_adapter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic   clk,
  input  logic   rst_n,
  native_if.slave native,
  axil_if.master  m_axil
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                state_q,        state_d;
  logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,        wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,        wstrb_d;
  logic                  awvalid_q,      awvalid_d;
  logic                  wvalid_q,       wvalid_d;
  logic                  arvalid_q,      arvalid_d;
  logic                  bready_q,       bready_d;
  logic                  rready_q,       rready_d;
  logic                  native_ready_q, native_ready_d;
  logic [DATA_WIDTH-1:0] rdata_q,        rdata_d;
  logic                  error_q,        error_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      bready_q       <= 1'b0;
      rready_q       <= 1'b0;
      native_ready_q <= 1'b0;
      rdata_q        <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      arvalid_q      <= arvalid_d;
      bready_q       <= bready_d;
      rready_q       <= rready_d;
      native_ready_q <= native_ready_d;
      rdata_q        <= rdata_d;
      error_q        <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    arvalid_d      = arvalid_q;
    bready_d       = bready_q;
    rready_d       = rready_q;
    native_ready_d = 1'b0;
    rdata_d        = rdata_q;
    error_d        = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (native.native_valid) begin
          addr_d  = native.native_addr;
          wdata_d = native.native_wdata;
          wstrb_d = native.native_wstrb;
          if (native.native_wstrb != '0) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W retire independently; leave once neither is still pending
      S_WR_REQ: begin
        if (awvalid_q && m_axil.m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.m_axil_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (m_axil.m_axil_bvalid) begin
          state_d        = S_DONE;
          bready_d       = 1'b0;
          error_d        = |m_axil.m_axil_bresp;
          native_ready_d = 1'b1;
        end
      end

      S_RD_REQ: begin
        if (m_axil.m_axil_arready) begin
          state_d   = S_RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      S_RD_RESP: begin
        if (m_axil.m_axil_rvalid) begin
          state_d        = S_DONE;
          rready_d       = 1'b0;
          rdata_d        = m_axil.m_axil_rdata;
          error_d        = |m_axil.m_axil_rresp;
          native_ready_d = 1'b1;
        end
      end

      // native_ready is high for this single cycle; any held request waits for IDLE
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign native.native_ready  = native_ready_q;
  assign native.native_rdata  = rdata_q;
  assign native.native_error  = error_q;

  assign m_axil.m_axil_awaddr  = addr_q;
  assign m_axil.m_axil_awprot  = 3'b000;
  assign m_axil.m_axil_awvalid = awvalid_q;
  assign m_axil.m_axil_wdata   = wdata_q;
  assign m_axil.m_axil_wstrb   = wstrb_q;
  assign m_axil.m_axil_wvalid  = wvalid_q;
  assign m_axil.m_axil_bready  = bready_q;
  assign m_axil.m_axil_araddr  = addr_q;
  assign m_axil.m_axil_arprot  = 3'b000;
  assign m_axil.m_axil_arvalid = arvalid_q;
  assign m_axil.m_axil_rready  = rready_q;

endmodule

// File: tb/tb_native2axil_adapter.sv
// Directed bench for native2axil_adapter: scoreboarded native master plus a delay-configurable AXI4-Lite slave.
`timescale 1ns/1ps

module tb_native2axil_adapter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  native_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nat ();
  axil_if   #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

  native2axil_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .native (nat),
    .m_axil (axil)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_ar[$];
  rsp_t          exp_rsp[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour knobs
  int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0]    cfg_bresp, cfg_rresp;
  logic [DW-1:0] cfg_rdata;
  logic [DW-1:0] last_rd;

  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit aw_got, w_got, ar_got;
  int n_aw, n_w, n_b, n_ar, n_r, n_rdy;
  int e_aw, e_b, e_ar, e_rdy;
  int cyc;
  int aw_start, w_start;

  always @(posedge clk) cyc++;

  // AXI4-Lite slave: drives at negedge; a *_hs flag means the handshake happens at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      axil.m_axil_awready = 1'b0; axil.m_axil_wready = 1'b0; axil.m_axil_arready = 1'b0;
      axil.m_axil_bvalid  = 1'b0; axil.m_axil_bresp  = 2'b00;
      axil.m_axil_rvalid  = 1'b0; axil.m_axil_rresp  = 2'b00; axil.m_axil_rdata = '0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (aw_hs) begin
        aw_hs = 0; axil.m_axil_awready = 1'b0; aw_got = 1; n_aw++;
        check("awvalid_drop", 64'(axil.m_axil_awvalid), 64'd0);
      end else if (axil.m_axil_awvalid && !axil.m_axil_awready) begin
        if (aw_cnt == 0) aw_start = cyc;
        if (aw_cnt >= aw_wait) begin
          axil.m_axil_awready = 1'b1; aw_cnt = 0;
          if (exp_wr.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else begin
            check("awaddr", 64'(axil.m_axil_awaddr), 64'(exp_wr[0].addr));
            check("awprot", 64'(axil.m_axil_awprot), 64'd0);
          end
        end else aw_cnt++;
      end
      if (axil.m_axil_awready && axil.m_axil_awvalid) aw_hs = 1;

      if (w_hs) begin
        w_hs = 0; axil.m_axil_wready = 1'b0; w_got = 1; n_w++;
        check("wvalid_drop", 64'(axil.m_axil_wvalid), 64'd0);
      end else if (axil.m_axil_wvalid && !axil.m_axil_wready) begin
        if (w_cnt == 0) w_start = cyc;
        if (w_cnt >= w_wait) begin
          axil.m_axil_wready = 1'b1; w_cnt = 0;
          if (exp_wr.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else begin
            check("wdata", 64'(axil.m_axil_wdata), 64'(exp_wr[0].data));
            check("wstrb", 64'(axil.m_axil_wstrb), 64'(exp_wr[0].strb));
          end
        end else w_cnt++;
      end
      if (axil.m_axil_wready && axil.m_axil_wvalid) w_hs = 1;

      if (b_hs) begin
        b_hs = 0; axil.m_axil_bvalid = 1'b0; n_b++;
      end else if (aw_got && w_got && !axil.m_axil_bvalid) begin
        if (b_cnt >= b_wait) begin
          axil.m_axil_bvalid = 1'b1; axil.m_axil_bresp = cfg_bresp;
          aw_got = 0; w_got = 0; b_cnt = 0;
          if (exp_wr.size() > 0) void'(exp_wr.pop_front());
        end else b_cnt++;
      end
      if (axil.m_axil_bvalid && axil.m_axil_bready) b_hs = 1;

      if (ar_hs) begin
        ar_hs = 0; axil.m_axil_arready = 1'b0; ar_got = 1; n_ar++;
        check("arvalid_drop", 64'(axil.m_axil_arvalid), 64'd0);
      end else if (axil.m_axil_arvalid && !axil.m_axil_arready) begin
        if (ar_cnt >= ar_wait) begin
          axil.m_axil_arready = 1'b1; ar_cnt = 0;
          if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
          else begin
            check("araddr", 64'(axil.m_axil_araddr), 64'(exp_ar.pop_front()));
            check("arprot", 64'(axil.m_axil_arprot), 64'd0);
          end
        end else ar_cnt++;
      end
      if (axil.m_axil_arready && axil.m_axil_arvalid) ar_hs = 1;

      if (r_hs) begin
        r_hs = 0; axil.m_axil_rvalid = 1'b0; n_r++;
      end else if (ar_got && !axil.m_axil_rvalid) begin
        if (r_cnt >= r_wait) begin
          axil.m_axil_rvalid = 1'b1; axil.m_axil_rdata = cfg_rdata; axil.m_axil_rresp = cfg_rresp;
          ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (axil.m_axil_rvalid && axil.m_axil_rready) r_hs = 1;
    end
  end

  // Native response monitor: pops the scoreboard on every native_ready
  bit   prev_rdy;
  rsp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) prev_rdy = 1'b0;
    else begin
      if (nat.native_ready) begin
        n_rdy++;
        check("ready_one_cycle", 64'(prev_rdy), 64'd0);
        if (exp_rsp.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_rsp.pop_front();
          check("native_rdata", 64'(nat.native_rdata), 64'(mon_e.rdata));
          check("native_error", 64'(nat.native_error), 64'(mon_e.err));
        end
      end
      prev_rdy = nat.native_ready;
    end
  end

  // Issue one request, push its expectations, wait (bounded) for native_ready
  task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input bit keep, output int lat);
    rsp_t e;
    wr_t  w;
    bit   done;
    if (s != '0) begin
      w.addr = a; w.data = d; w.strb = s;
      exp_wr.push_back(w);
      e.rdata = last_rd; e.err = |cfg_bresp;
      e_aw++; e_b++;
    end else begin
      exp_ar.push_back(a);
      e.rdata = cfg_rdata; e.err = |cfg_rresp;
      last_rd = cfg_rdata;
      e_ar++;
    end
    e_rdy++;
    exp_rsp.push_back(e);
    nat.native_addr  = a;
    nat.native_wdata = d;
    nat.native_wstrb = s;
    nat.native_valid = 1'b1;
    lat = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (nat.native_ready) done = 1;
      else lat++;
    end
    check("txn_timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
    if (!keep) nat.native_valid = 1'b0;
  endtask

  task automatic set_waits(input int aw_w, input int w_w, input int b_w, input int ar_w, input int r_w);
    aw_wait = aw_w; w_wait = w_w; b_wait = b_w; ar_wait = ar_w; r_wait = r_w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a0, r0;
    bit seen;

    rst_n = 1'b0;
    nat.native_valid = 1'b0; nat.native_addr = '0; nat.native_wdata = '0; nat.native_wstrb = '0;
    set_waits(0, 0, 0, 0, 0);
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0; last_rd = '0;
    e_aw = 0; e_b = 0; e_ar = 0; e_rdy = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_native_ready", 64'(nat.native_ready), 64'd0);
    check("rst_native_rdata", 64'(nat.native_rdata), 64'd0);
    check("rst_native_error", 64'(nat.native_error), 64'd0);
    check("rst_awvalid", 64'(axil.m_axil_awvalid), 64'd0);
    check("rst_wvalid", 64'(axil.m_axil_wvalid), 64'd0);
    check("rst_arvalid", 64'(axil.m_axil_arvalid), 64'd0);
    check("rst_bready", 64'(axil.m_axil_bready), 64'd0);
    check("rst_rready", 64'(axil.m_axil_rready), 64'd0);
    check("rst_awaddr", 64'(axil.m_axil_awaddr), 64'd0);
    @(posedge clk); #1;

    // Zero-wait write: aw/w together at T1, native_ready at T3
    do_txn(32'h10, 32'hA5A5_0001, 4'hF, 1'b0, lat);
    check("wr_latency", 64'(lat), 64'd3);
    check("aw_w_same_cycle", 64'(aw_start), 64'(w_start));

    // Read: arready 2 cycles late, rvalid 3 cycles after AR -> native_ready at T8
    set_waits(0, 0, 0, 2, 3);
    cfg_rdata = 32'hDEAD_BEEF;
    do_txn(32'h20, '0, 4'h0, 1'b0, lat);
    check("rd_latency", 64'(lat), 64'd8);

    // W accepted 4 cycles after AW; native_rdata must still hold the read value
    set_waits(0, 4, 0, 0, 0);
    a0 = n_aw;
    do_txn(32'h44, 32'h1234_5678, 4'b0011, 1'b0, lat);
    check("wr_wlate_latency", 64'(lat), 64'd7);
    check("wr_wlate_single_aw", 64'(n_aw - a0), 64'd1);

    // AW accepted later than W
    set_waits(3, 0, 1, 0, 0);
    do_txn(32'h48, 32'hCAFE_0002, 4'b1000, 1'b0, lat);
    check("wr_awlate_latency", 64'(lat), 64'd7);

    // Error responses on both directions
    set_waits(0, 0, 0, 0, 0);
    cfg_bresp = 2'b10;
    do_txn(32'h50, 32'h0000_00FF, 4'h1, 1'b0, lat);
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11; cfg_rdata = 32'h0BAD_F00D;
    do_txn(32'h54, '0, 4'h0, 1'b0, lat);
    cfg_rresp = 2'b00;

    // Back-to-back with native_valid held across DONE
    cfg_rdata = 32'h1357_9BDF;
    a0 = n_aw; r0 = n_ar;
    do_txn(32'h60, 32'h5555_AAAA, 4'hF, 1'b1, lat);
    do_txn(32'h64, '0, 4'h0, 1'b0, lat);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_aw_count", 64'(n_aw - a0), 64'd1);
    check("b2b_ar_count", 64'(n_ar - r0), 64'd1);

    // Reset while waiting in WR_RESP
    set_waits(0, 0, 20, 0, 0);
    begin
      wr_t w;
      w.addr = 32'h70; w.data = 32'h7777_0000; w.strb = 4'hF;
      exp_wr.push_back(w);
    end
    e_aw++;
    nat.native_addr = 32'h70; nat.native_wdata = 32'h7777_0000; nat.native_wstrb = 4'hF;
    nat.native_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (axil.m_axil_bready) seen = 1;
    end
    check("reach_wr_resp", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_awvalid", 64'(axil.m_axil_awvalid), 64'd0);
    check("arst_wvalid", 64'(axil.m_axil_wvalid), 64'd0);
    check("arst_arvalid", 64'(axil.m_axil_arvalid), 64'd0);
    check("arst_bready", 64'(axil.m_axil_bready), 64'd0);
    check("arst_rready", 64'(axil.m_axil_rready), 64'd0);
    check("arst_native_ready", 64'(nat.native_ready), 64'd0);
    check("arst_native_rdata", 64'(nat.native_rdata), 64'd0);
    nat.native_valid = 1'b0;
    exp_wr.delete();
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    set_waits(0, 0, 0, 1, 1);
    cfg_rdata = 32'h2468_ACE0;
    do_txn(32'h80, '0, 4'h0, 1'b0, lat);

    repeat (4) @(posedge clk);
    #1;
    check("total_aw", 64'(n_aw), 64'(e_aw));
    check("total_w", 64'(n_w), 64'(e_aw));
    check("total_b", 64'(n_b), 64'(e_b));
    check("total_ar", 64'(n_ar), 64'(e_ar));
    check("total_r", 64'(n_r), 64'(e_ar));
    check("total_ready", 64'(n_rdy), 64'(e_rdy));
    check("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
